// File: rtl/key_pkg.sv
// Shared definitions for the key debounce array: per-channel FSM states,
// debounce counter width and the ms-tick divider helper.
package key_pkg;

  localparam int unsigned DB_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_WAIT = 2'd1,
    ST_HELD       = 2'd2,
    ST_REL_WAIT   = 2'd3
  } key_state_e;

  // sys_clk cycles per 1 ms tick
  function automatic int unsigned ms_tick_div(input int unsigned clk_hz);
    return clk_hz / 1000;
  endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One debounced key channel: press/release confirmation on ms ticks plus a
// long-press detector driven by a saturating hold counter.
module key_debounce_chan
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned LONG_MS     = 1000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic pressed_raw,
  input  logic ms_tick,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int unsigned HOLD_W = (LONG_MS > 0) ? $clog2(LONG_MS + 1) : 1;
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_MS);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_MS);
  localparam bit                LONG_EN   = (LONG_MS != 0);

  key_state_e         state, state_nxt;
  logic [DB_W-1:0]    db_cnt, db_nxt;
  logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
  logic               level_nxt, press_nxt, release_nxt, long_nxt;

  logic [DB_W-1:0]    db_inc;
  logic [HOLD_W-1:0]  hold_inc;
  logic               hold_adv, hold_hit;

  assign db_inc   = db_cnt + DB_W'(1);
  assign hold_inc = hold_cnt + HOLD_W'(1);
  // hold counter stops at LONG_MS, so the long pulse can fire only once per press
  assign hold_adv = ms_tick && LONG_EN && (hold_cnt < HOLD_LAST);
  assign hold_hit = hold_adv && (hold_inc == HOLD_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= ST_IDLE;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      state         <= state_nxt;
      db_cnt        <= db_nxt;
      hold_cnt      <= hold_nxt;
      level         <= level_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
      long_pulse    <= long_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    db_nxt      = db_cnt;
    hold_nxt    = hold_cnt;
    level_nxt   = level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    long_nxt    = 1'b0;

    case (state)
      ST_IDLE: begin
        level_nxt = 1'b0;
        if (pressed_raw) begin
          state_nxt = ST_PRESS_WAIT;
          db_nxt    = '0;
        end
      end

      ST_PRESS_WAIT: begin
        if (!pressed_raw) begin
          state_nxt = ST_IDLE;
        end else if (ms_tick) begin
          db_nxt = db_inc;
          if (db_inc == DB_LAST) begin
            state_nxt = ST_HELD;
            press_nxt = 1'b1;
            level_nxt = 1'b1;
            hold_nxt  = '0;
          end
        end
      end

      ST_HELD: begin
        if (hold_adv) hold_nxt = hold_inc;
        long_nxt = hold_hit;
        if (!pressed_raw) begin
          state_nxt = ST_REL_WAIT;
          db_nxt    = '0;
        end
      end

      ST_REL_WAIT: begin
        if (hold_adv) hold_nxt = hold_inc;
        long_nxt = hold_hit;
        if (pressed_raw) begin
          state_nxt = ST_HELD;
        end else if (ms_tick) begin
          db_nxt = db_inc;
          if (db_inc == DB_LAST) begin
            state_nxt   = ST_IDLE;
            release_nxt = 1'b1;
            level_nxt   = 1'b0;
            // a long pulse never shares a cycle with the release pulse
            long_nxt    = 1'b0;
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        db_nxt    = '0;
        hold_nxt  = '0;
        level_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/key_debounce_array.sv
// Array of independent debounced keys sharing one ms-tick prescaler; each raw
// pin is synchronised and normalised to active-high before its channel FSM.
module key_debounce_array
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS    = 4,
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned LONG_MS     = 1000,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  localparam int unsigned TICK_DIV = ms_tick_div(CLK_HZ);
  localparam int unsigned PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [NUM_KEYS-1:0] REL_LVL  = ACTIVE_LOW ? '1 : '0;

  logic [PRE_W-1:0]    pre_cnt;
  logic                ms_tick;
  logic [NUM_KEYS-1:0] sync1, sync2;
  logic [NUM_KEYS-1:0] pressed_raw;

  // free-running ms prescaler shared by all channels
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pre_cnt <= '0;
      ms_tick <= 1'b0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
      ms_tick <= 1'b1;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
      ms_tick <= 1'b0;
    end
  end

  // two-flop synchroniser, reset to the released pin level
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1 <= REL_LVL;
      sync2 <= REL_LVL;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  assign pressed_raw = sync2 ^ {NUM_KEYS{ACTIVE_LOW}};

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    key_debounce_chan #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .LONG_MS     (LONG_MS)
    ) u_chan (
      .sys_clk       (sys_clk),
      .sys_rst_n     (sys_rst_n),
      .pressed_raw   (pressed_raw[i]),
      .ms_tick       (ms_tick),
      .level         (key_level[i]),
      .press_pulse   (key_press[i]),
      .release_pulse (key_release[i]),
      .long_pulse    (key_long[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_array.sv
// Directed bench for key_debounce_array: 10 cycles per ms tick, 10-tick debounce,
// 50-tick long press, four active-low keys.
module tb_key_debounce_array;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [3:0] key_in = 4'hF;
  logic [3:0] key_level, key_press, key_release, key_long;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int press_cnt[4], rel_cnt[4], long_cnt[4];
  int press_cyc[4], rel_cyc[4], long_cyc[4];
  int viol = 0;

  key_debounce_array #(
    .NUM_KEYS    (4),
    .CLK_HZ      (10_000),
    .DEBOUNCE_MS (10),
    .LONG_MS     (50),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .key_in      (key_in),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc++;

  // pulse monitor sampled mid-cycle
  always @(negedge sys_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (key_press[i])   begin press_cnt[i]++; press_cyc[i] = cyc; end
      if (key_release[i]) begin rel_cnt[i]++;   rel_cyc[i]   = cyc; end
      if (key_long[i])    begin long_cnt[i]++;  long_cyc[i]  = cyc; end
      if ((key_press[i] && key_release[i]) || (key_long[i] && (key_press[i] || key_release[i])))
        viol++;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  function automatic int pulses_total();
    int s = 0;
    for (int i = 0; i < 4; i++) s += press_cnt[i] + rel_cnt[i] + long_cnt[i];
    return s;
  endfunction

  function automatic int in_window(input int lat);
    return (lat >= 93 && lat <= 103) ? 1 : 0;
  endfunction

  initial begin
    int c0, p, r, l, base;

    // reset state
    step(3);
    @(negedge sys_clk);
    check("rst_level",   int'(key_level),   0);
    check("rst_press",   int'(key_press),   0);
    check("rst_release", int'(key_release), 0);
    check("rst_long",    int'(key_long),    0);
    step(1);
    sys_rst_n = 1'b1;
    step(20);

    // clean press on key 0
    p = press_cnt[0];
    key_in[0] = 1'b0;
    c0 = cyc;
    step(300);
    check("t1_press_cnt", press_cnt[0] - p, 1);
    check("t1_press_lat", in_window(press_cyc[0] - c0), 1);
    check("t1_level", int'(key_level[0]), 1);

    // release with a 40-cycle bounce, then a stable release
    r = rel_cnt[0];
    l = long_cnt[0];
    key_in[0] = 1'b1;
    step(40);
    key_in[0] = 1'b0;
    step(60);
    check("t4_bounce_no_release", rel_cnt[0] - r, 0);
    check("t4_bounce_level", int'(key_level[0]), 1);
    key_in[0] = 1'b1;
    c0 = cyc;
    step(150);
    check("t4_release_cnt", rel_cnt[0] - r, 1);
    check("t4_release_lat", in_window(rel_cyc[0] - c0), 1);
    check("t4_level", int'(key_level[0]), 0);
    check("t4_short_no_long", long_cnt[0] - l, 0);

    // key 1 chattering every 30 cycles
    base = pulses_total();
    for (int i = 0; i < 20; i++) begin
      key_in[1] = ~key_in[1];
      step(30);
    end
    step(150);
    check("t2_no_pulses", pulses_total() - base, 0);
    check("t2_level", int'(key_level[1]), 0);

    // key 2 long hold
    p = press_cnt[2];
    l = long_cnt[2];
    r = rel_cnt[2];
    key_in[2] = 1'b0;
    step(800);
    check("t3_press_cnt", press_cnt[2] - p, 1);
    check("t3_long_cnt", long_cnt[2] - l, 1);
    check("t3_long_delay", long_cyc[2] - press_cyc[2], 500);
    check("t3_level", int'(key_level[2]), 1);
    key_in[2] = 1'b1;
    step(150);
    check("t3_long_once", long_cnt[2] - l, 1);
    check("t3_release_cnt", rel_cnt[2] - r, 1);
    check("t3_level_off", int'(key_level[2]), 0);

    // keys 0 and 3 pressed together
    p = press_cnt[0];
    base = press_cnt[3];
    key_in = key_in & 4'b0110;
    step(150);
    check("t5_press0", press_cnt[0] - p, 1);
    check("t5_press3", press_cnt[3] - base, 1);
    check("t5_same_cycle", press_cyc[3] - press_cyc[0], 0);
    check("t5_levels", int'(key_level), 9);
    key_in = 4'hF;
    step(150);
    check("t5_levels_off", int'(key_level), 0);

    // reset 50 cycles into PRESS_WAIT with key 1 held
    key_in[1] = 1'b0;
    step(50);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    check("t6_rst_level", int'(key_level), 0);
    check("t6_rst_press", int'(key_press), 0);
    step(3);
    p = press_cnt[1];
    sys_rst_n = 1'b1;
    c0 = cyc;
    step(300);
    check("t6_press_cnt", press_cnt[1] - p, 1);
    check("t6_press_lat", in_window(press_cyc[1] - c0), 1);
    check("t6_level", int'(key_level[1]), 1);

    // reset while HELD clears the level immediately
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    check("t6_held_rst_level", int'(key_level), 0);
    step(3);
    r = rel_cnt[1];
    sys_rst_n = 1'b1;
    key_in[1] = 1'b1;
    step(150);
    check("t6_no_release", rel_cnt[1] - r, 0);
    check("t6_level_off", int'(key_level[1]), 0);

    check("pulse_exclusive", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_debounce_array.md
KEY_DEBOUNCE_ARRAY -- requirements
Module: key_debounce_array

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 4, number of independent key channels (1..32).
REQ-002 SHALL have parameter CLK_HZ, default 50_000_000, sys_clk frequency; TICK_DIV = CLK_HZ/1000 cycles per ms tick.
REQ-003 SHALL have parameter DEBOUNCE_MS, default 10, stable time required to confirm a press or a release (1..255).
REQ-004 SHALL have parameter LONG_MS, default 1000, hold time that triggers the long-press pulse; 0 disables it.
REQ-005 SHALL have parameter ACTIVE_LOW, default 1; when set, key_in=0 means pressed.
REQ-006 SHALL have port sys_clk  input  1  clock.
REQ-007 SHALL have port sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port key_in  input  NUM_KEYS  raw asynchronous key pins.
REQ-009 SHALL have port key_level  output  NUM_KEYS  debounced state, 1 = pressed.
REQ-010 SHALL have port key_press  output  NUM_KEYS  one-cycle pulse on confirmed press.
REQ-011 SHALL have port key_release  output  NUM_KEYS  one-cycle pulse on confirmed release.
REQ-012 SHALL have port key_long  output  NUM_KEYS  one-cycle pulse, at most once per press, when the hold reaches LONG_MS.

Function
REQ-013 Each key_in bit SHALL pass through a 2-flop synchroniser; pressed_raw = synchronised bit XOR ACTIVE_LOW.
REQ-014 A single shared free-running prescaler SHALL assert ms_tick for one cycle every TICK_DIV cycles.
REQ-015 Each channel SHALL run an FSM with states IDLE, PRESS_WAIT, HELD, REL_WAIT and an 8-bit debounce counter db_cnt.
REQ-016 IDLE: pressed_raw=1 -> PRESS_WAIT, db_cnt=0.
REQ-017 PRESS_WAIT: pressed_raw=0 -> IDLE; else db_cnt increments on ms_tick; the tick that makes db_cnt==DEBOUNCE_MS -> HELD, key_press pulse, key_level=1.
REQ-018 HELD: pressed_raw=0 -> REL_WAIT, db_cnt=0.
REQ-019 REL_WAIT: pressed_raw=1 -> HELD, no pulse, key_level stays 1; else db_cnt increments on ms_tick; the tick that makes db_cnt==DEBOUNCE_MS -> IDLE, key_release pulse, key_level=0.
REQ-020 Press and release confirmation SHALL be symmetric: same DEBOUNCE_MS tick count in both directions.
REQ-021 Confirmation latency from a key_in edge SHALL lie within [(DEBOUNCE_MS-1)*TICK_DIV+3, DEBOUNCE_MS*TICK_DIV+3] cycles.
REQ-022 Hold counter hold_cnt (width clog2(LONG_MS+1)) SHALL clear on entering HELD from PRESS_WAIT, increment on ms_tick in HELD and REL_WAIT, and saturate at LONG_MS.
REQ-023 key_long SHALL pulse on the tick where hold_cnt reaches LONG_MS, only if LONG_MS!=0, and never again until IDLE is re-entered.
REQ-024 Channels SHALL be fully independent; simultaneous events on several channels SHALL produce pulses in the same cycle.
REQ-025 key_press and key_release for one channel SHALL never assert in the same cycle; key_long may coincide with neither.
REQ-026 All outputs SHALL be registered; pulses SHALL be exactly one sys_clk cycle wide.
REQ-027 Unreachable FSM encodings SHALL return to IDLE on the next cycle with outputs 0.

Reset
REQ-028 On sys_rst_n=0: all FSMs IDLE, db_cnt, hold_cnt and the prescaler cleared, synchroniser flops set to the released level (ACTIVE_LOW ? 1 : 0).
REQ-029 On reset, key_level, key_press, key_release and key_long SHALL all be 0, including reset asserted mid-PRESS_WAIT or mid-HELD.
REQ-030 After reset release, a key already held SHALL need a full debounce interval before key_press.

Structure
REQ-031 Shared package key_pkg SHALL hold the FSM state encodings and the ms-tick divider constant function.
REQ-032 The per-channel FSM SHALL be sub-module key_debounce_chan, instantiated NUM_KEYS times; the prescaler stays in the top level.

Verification (CLK_HZ=10_000, TICK_DIV=10, DEBOUNCE_MS=10, LONG_MS=50, NUM_KEYS=4, ACTIVE_LOW=1)
REQ-033 Clean press on key 0 held 300 cycles -> exactly one key_press[0] 93..103 cycles after the edge; key_level[0]=1.
REQ-034 Key 1 toggling every 30 cycles for 600 cycles -> no pulses on any output; key_level[1]=0.
REQ-035 Key 2 held 800 cycles -> key_press, then a single key_long about 500 cycles later; no further key_long.
REQ-036 Release of key 0 with a 40-cycle bounce back to pressed -> no release; then a stable release gives one key_release 93..103 cycles after it; key_level=0.
REQ-037 Keys 0 and 3 pressed in the same cycle -> key_press[0] and key_press[3] asserted in the same cycle.
REQ-038 Reset pulsed 50 cycles into PRESS_WAIT with the key still held -> all outputs 0; key_press only 93..103 cycles after reset release.
